// File: rtl/gshare_predictor_pkg.sv
// Shared constants and helpers for the gshare/bimodal branch predictor.
package gshare_predictor_pkg;

  localparam int WORD_LEN = 32;

  typedef enum logic {
    BP_MODE_BIMODAL = 1'b0,
    BP_MODE_GSHARE  = 1'b1
  } bp_mode_e;

  localparam int BP_MIN_CTR_WIDTH = 1;
  localparam int BP_MIN_GHR_BITS  = 1;

  // Weakly not-taken start value; collapses to 0 for 1-bit counters.
  function automatic int bp_ctr_init(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/gshare_predictor_ghr.sv
// Speculative global history register: shifts in predictions at IF and is
// repaired from ID on a mispredict, which wins over a same-cycle shift.
module bp_global_history #(
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en_i,
  input  logic                shift_bit_i,
  input  logic                recover_en_i,
  input  logic [GHR_BITS-1:0] recover_ghr_i,
  input  logic                recover_bit_i,
  output logic [GHR_BITS-1:0] ghr_o
);

  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Shift form keeps GHR_BITS=1 legal (no zero-width slice).
  always_comb begin
    ghr_d = ghr_q;
    if (recover_en_i)
      ghr_d = (recover_ghr_i << 1) | GHR_BITS'(recover_bit_i);
    else if (shift_en_i)
      ghr_d = (ghr_q << 1) | GHR_BITS'(shift_bit_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/gshare_predictor.sv
// Branch direction predictor beside IF: PHT of saturating counters indexed by
// PC (bimodal) or PC^GHR (gshare), trained from ID, with hit/miss statistics.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int PHT_BITS  = 6,
  parameter int GHR_BITS  = 6,
  parameter int CTR_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                pred_req,
  input  logic [WORD_LEN-1:0] pc_IF,
  output logic                predict_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                update_en,
  input  logic [WORD_LEN-1:0] pc_ID,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                update_pred,
  input  logic                actual_taken,
  output logic [31:0]         predictions_total,
  output logic [31:0]         predictions_correct,
  output logic [31:0]         predictions_wrong
);

  if (GHR_BITS > PHT_BITS || GHR_BITS < BP_MIN_GHR_BITS || CTR_WIDTH < BP_MIN_CTR_WIDTH) begin : g_bad_params
    $error("gshare_predictor: need 1 <= GHR_BITS <= PHT_BITS and CTR_WIDTH >= 1");
  end

  localparam int                   PHT_ENTRIES = 1 << PHT_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT    = CTR_WIDTH'(bp_ctr_init(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;

  logic [CTR_WIDTH-1:0] pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0]  ghr;
  logic [PHT_BITS-1:0]  pred_idx, upd_idx;
  logic [CTR_WIDTH-1:0] upd_ctr, upd_ctr_d;
  logic                 mispredict;
  logic [31:0]          total_q, correct_q, wrong_q;
  logic                 unused_pc;

  assign unused_pc = ^{pc_IF[WORD_LEN-1:PHT_BITS+2], pc_IF[1:0],
                       pc_ID[WORD_LEN-1:PHT_BITS+2], pc_ID[1:0]};

  always_comb begin
    pred_idx = pc_IF[PHT_BITS+1:2];
    upd_idx  = pc_ID[PHT_BITS+1:2];
    if (mode == BP_MODE_GSHARE) begin
      pred_idx = pred_idx ^ PHT_BITS'(ghr);
      upd_idx  = upd_idx ^ PHT_BITS'(update_ghr);
    end
  end

  assign predict_taken = pht_q[pred_idx][CTR_WIDTH-1];
  assign pred_ghr      = ghr;
  assign mispredict    = update_en && (update_pred != actual_taken);

  always_comb begin
    upd_ctr   = pht_q[upd_idx];
    upd_ctr_d = upd_ctr;
    if (actual_taken && upd_ctr != CTR_MAX)
      upd_ctr_d = upd_ctr + 1'b1;
    else if (!actual_taken && upd_ctr != '0)
      upd_ctr_d = upd_ctr - 1'b1;
  end

  // Prediction reads the array combinationally, so a colliding update is seen next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_INIT;
    end else if (update_en) begin
      pht_q[upd_idx] <= upd_ctr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q   <= '0;
      correct_q <= '0;
      wrong_q   <= '0;
    end else if (update_en) begin
      total_q <= total_q + 32'd1;
      if (mispredict) wrong_q   <= wrong_q + 32'd1;
      else            correct_q <= correct_q + 32'd1;
    end
  end

  assign predictions_total   = total_q;
  assign predictions_correct = correct_q;
  assign predictions_wrong   = wrong_q;

  bp_global_history #(.GHR_BITS(GHR_BITS)) u_ghr (
    .clk           (clk),
    .rst           (rst),
    .shift_en_i    (pred_req),
    .shift_bit_i   (predict_taken),
    .recover_en_i  (mispredict),
    .recover_ghr_i (update_ghr),
    .recover_bit_i (actual_taken),
    .ghr_o         (ghr)
  );

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_gshare_predictor;
  import gshare_predictor_pkg::*;

  localparam int S_PT = 0, S_GHR = 1, S_TOT = 2, S_COR = 3, S_WRG = 4;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    int          tag;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, mode = 1'b0, pred_req = 1'b0;
  logic        update_en = 1'b0, update_pred = 1'b0, actual_taken = 1'b0;
  logic [31:0] pc_IF = '0, pc_ID = '0;
  logic [5:0]  update_ghr = '0;
  logic        predict_taken;
  logic [5:0]  pred_ghr;
  logic [31:0] predictions_total, predictions_correct, predictions_wrong;

  int   checks = 0, errors = 0;
  exp_t sb_q[$];

  gshare_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .mode                (mode),
    .pred_req            (pred_req),
    .pc_IF               (pc_IF),
    .predict_taken       (predict_taken),
    .pred_ghr            (pred_ghr),
    .update_en           (update_en),
    .pc_ID               (pc_ID),
    .update_ghr          (update_ghr),
    .update_pred         (update_pred),
    .actual_taken        (actual_taken),
    .predictions_total   (predictions_total),
    .predictions_correct (predictions_correct),
    .predictions_wrong   (predictions_wrong)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual_of(input int sel);
    case (sel)
      S_PT:    return {31'd0, predict_taken};
      S_GHR:   return {26'd0, pred_ghr};
      S_TOT:   return predictions_total;
      S_COR:   return predictions_correct;
      default: return predictions_wrong;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_PT:    return "predict_taken";
      S_GHR:   return "pred_ghr";
      S_TOT:   return "total";
      S_COR:   return "correct";
      default: return "wrong";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = actual_of(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", sel_name(e.sel), e.tag, act, e.exp);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] v, input int tag);
    exp_t e;
    e.sel = sel; e.exp = v; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic chk_stats(input int t, input int c, input int w, input int tag);
    push(S_TOT, 32'(t), tag);
    push(S_COR, 32'(c), tag);
    push(S_WRG, 32'(w), tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_req  = 1'b0;
    update_en = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [5:0] g, input logic p, input logic a);
    update_en    = 1'b1;
    pc_ID        = pc;
    update_ghr   = g;
    update_pred  = p;
    actual_taken = a;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset defaults
    idle(); mode = 1'b0;
    pc_IF = 32'h0;  push(S_PT, 0, 1); push(S_GHR, 0, 1); chk_stats(0, 0, 0, 1); tick();
    pc_IF = 32'h40; push(S_PT, 0, 2); tick();
    pc_IF = 32'hFC; push(S_PT, 0, 3); tick();

    // bimodal training of index 16
    upd(32'h40, 6'd0, 1'b0, 1'b1); pc_IF = 32'h40; push(S_PT, 0, 10); tick();
    upd(32'h40, 6'd0, 1'b1, 1'b1); push(S_PT, 1, 11); chk_stats(1, 0, 1, 11); tick();
    idle(); push(S_PT, 1, 12); push(S_GHR, 1, 12); chk_stats(2, 1, 1, 12); tick();

    // saturation and hysteresis
    repeat (5) begin upd(32'h40, 6'd0, 1'b1, 1'b1); tick(); end
    idle(); push(S_PT, 1, 20); tick();
    upd(32'h40, 6'd0, 1'b1, 1'b0); tick();
    idle(); push(S_PT, 1, 21); push(S_GHR, 0, 21); tick();
    repeat (6) begin upd(32'h40, 6'd0, 1'b0, 1'b0); tick(); end
    idle(); push(S_PT, 0, 22); chk_stats(14, 12, 2, 22); tick();

    // gshare indexing: train index 19 via pc 0x40 ^ history 000011
    mode = 1'b1;
    upd(32'h40, 6'b000011, 1'b1, 1'b1); tick();
    upd(32'h40, 6'b000011, 1'b1, 1'b1); tick();
    upd(32'h40, 6'b000001, 1'b0, 1'b1); tick();
    idle(); pc_IF = 32'h40; push(S_GHR, 3, 30); push(S_PT, 1, 30); tick();
    mode = 1'b0; push(S_PT, 0, 31); tick();
    pc_IF = 32'h4C; push(S_PT, 1, 32); chk_stats(17, 14, 3, 32); tick();

    // history shifting and recovery
    upd(32'h80, 6'd0, 1'b1, 1'b0); tick();
    idle(); mode = 1'b1; pc_IF = 32'h40; push(S_PT, 0, 40); push(S_GHR, 0, 40); tick();
    mode = 1'b0; pred_req = 1'b1;
    pc_IF = 32'h4C; push(S_PT, 1, 41); push(S_GHR, 0, 41); tick();
    pc_IF = 32'h40; push(S_PT, 0, 42); push(S_GHR, 1, 42); tick();
    pc_IF = 32'h4C; push(S_PT, 1, 43); push(S_GHR, 2, 43); tick();
    idle(); push(S_GHR, 5, 44); tick();
    pred_req = 1'b1; pc_IF = 32'h40; upd(32'h80, 6'b000101, 1'b0, 1'b1); push(S_PT, 0, 45); tick();
    idle(); push(S_GHR, 11, 46); tick();
    upd(32'h80, 6'd0, 1'b1, 1'b1); tick();
    idle(); push(S_GHR, 11, 47); chk_stats(20, 15, 5, 47); tick();

    // same-cycle read/write collision on index 16
    upd(32'h40, 6'd0, 1'b0, 1'b1); tick();
    pc_IF = 32'h40; upd(32'h40, 6'd0, 1'b1, 1'b1); push(S_PT, 0, 50); tick();
    idle(); push(S_PT, 1, 51); chk_stats(22, 16, 6, 51); tick();

    // asynchronous reset mid-sequence
    pred_req = 1'b1; pc_IF = 32'h4C; upd(32'h4C, 6'd0, 1'b0, 1'b1);
    rst = 1'b1;
    push(S_PT, 0, 52); push(S_GHR, 0, 52); chk_stats(0, 0, 0, 52); tick();
    rst = 1'b0; idle(); pc_IF = 32'h40; push(S_PT, 0, 53); tick();

    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
